// File: rtl/uart_time_pkg.sv
// Shared constants, types and byte-classification helpers for the UART
// stopwatch time parser. Frames look like "HH:MM:SS.d" (10 ASCII bytes).
package uart_time_pkg;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_5     = 8'h35;
  localparam logic [7:0] ASCII_9     = 8'h39;

  localparam int FRAME_LEN = 10;

  // What kind of byte each frame position expects.
  typedef enum logic [1:0] {
    PC_DIGIT,
    PC_COLON,
    PC_DOT,
    PC_RANGE
  } pos_class_e;

  // Parser position; POS_0 means hunting for the first digit of a frame.
  typedef enum logic [3:0] {
    POS_0 = 4'd0,
    POS_1 = 4'd1,
    POS_2 = 4'd2,
    POS_3 = 4'd3,
    POS_4 = 4'd4,
    POS_5 = 4'd5,
    POS_6 = 4'd6,
    POS_7 = 4'd7,
    POS_8 = 4'd8,
    POS_9 = 4'd9
  } pos_e;

  function automatic pos_class_e pos_class(input pos_e p);
    pos_class_e c;
    c = PC_DIGIT;
    case (p)
      POS_2, POS_5: c = PC_COLON;
      POS_8:        c = PC_DOT;
      POS_3, POS_6: c = PC_RANGE;
      default:      c = PC_DIGIT;
    endcase
    return c;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  // True when byte b is acceptable at position p (tens of minutes and
  // seconds are limited to 0..5).
  function automatic logic byte_ok(input pos_e p, input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    case (pos_class(p))
      PC_DIGIT: ok = is_digit(b);
      PC_COLON: ok = (b == ASCII_COLON);
      PC_DOT:   ok = (b == ASCII_DOT);
      PC_RANGE: ok = (b >= ASCII_0) && (b <= ASCII_5);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Nibble index (6 = hours tens ... 0 = tenths) a digit position lands in.
  function automatic logic [2:0] digit_slot(input pos_e p);
    logic [2:0] s;
    s = 3'd0;
    case (p)
      POS_0:   s = 3'd6;
      POS_1:   s = 3'd5;
      POS_3:   s = 3'd4;
      POS_4:   s = 3'd3;
      POS_6:   s = 3'd2;
      POS_7:   s = 3'd1;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/uart_time_parser_if.sv
// FIFO-side connection between the time parser and the UART core.
// master: the parser (pops RX, pushes TX). slave: the UART FIFOs.
interface uart_time_parser_if;
  logic       rx_empty;
  logic [7:0] rd_data;
  logic       rd_uart;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] wr_data;

  modport master (
    input  rx_empty,
    input  rd_data,
    input  tx_full,
    output rd_uart,
    output wr_uart,
    output wr_data
  );

  modport slave (
    output rx_empty,
    output rd_data,
    output tx_full,
    input  rd_uart,
    input  wr_uart,
    input  wr_data
  );
endinterface

// File: rtl/uart_time_req_gen.sv
// Request generator: turns request pulses into a single TX push of 'R'.
// Optional macro UART_TIME_AUTO_REQ_EN adds a free-running request timer
// of REQ_PERIOD cycles whose wrap acts like an extra req pulse.
module uart_time_req_gen
  import uart_time_pkg::*;
#(
  parameter int REQ_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] wr_data,
  output logic       pending
);

  logic auto_wrap;
  logic fire;
  logic req_any;

`ifdef UART_TIME_AUTO_REQ_EN
  localparam int CNT_W = (REQ_PERIOD > 1) ? $clog2(REQ_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_PERIOD - 1);

  logic [CNT_W-1:0] period_cnt;

  // Free-running period counter; the last count produces one wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
    end else if (period_cnt == CNT_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  assign auto_wrap = (period_cnt == CNT_LAST);
`else
  assign auto_wrap = 1'b0;
`endif

  assign fire    = pending && !tx_full;
  assign req_any = req || auto_wrap;
  assign wr_data = ASCII_R;

  // Pending flag merges requests until the TX FIFO has room; a request in
  // the firing cycle re-arms it so it is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      wr_uart <= 1'b0;
    end else begin
      wr_uart <= fire;
      pending <= (pending && !fire) || req_any;
    end
  end

endmodule

// File: rtl/uart_time_parser.sv
// Host-side stopwatch time parser: requests the time with 'R', parses the
// "HH:MM:SS.d" reply into packed BCD and flags malformed/timed-out frames.
// Optional macro UART_TIME_AUTO_REQ_EN enables periodic automatic requests.
module uart_time_parser
  import uart_time_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int REQ_PERIOD  = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  uart_time_parser_if.master  uart,
  input  logic                req,
  output logic [27:0]         time_bcd,
  output logic                time_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  pos_e              pos;
  pos_e              pos_n;
  logic [27:0]       shadow;
  logic [27:0]       shadow_n;
  logic [27:0]       bcd_n;
  logic              valid_n;
  logic              err_n;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_n;
  logic [3:0]        nib;
  logic              pop;
  logic              pending;
  logic              wr_pulse;
  logic [7:0]        wr_byte;

  uart_time_req_gen #(
    .REQ_PERIOD(REQ_PERIOD)
  ) u_req_gen (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .tx_full (uart.tx_full),
    .wr_uart (wr_pulse),
    .wr_data (wr_byte),
    .pending (pending)
  );

  assign uart.wr_uart = wr_pulse;
  assign uart.wr_data = wr_byte;
  assign pop          = !uart.rx_empty;

  // State register: position, shadow digits, published time and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos        <= POS_0;
      shadow     <= '0;
      time_bcd   <= '0;
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      pos        <= pos_n;
      shadow     <= shadow_n;
      time_bcd   <= bcd_n;
      time_valid <= valid_n;
      frame_err  <= err_n;
      idle_cnt   <= idle_n;
    end
  end

  // Next-state logic: one byte per pop; a rejected byte is retried as a
  // possible frame start, and a stalled partial frame times out.
  always_comb begin
    pos_n    = pos;
    shadow_n = shadow;
    bcd_n    = time_bcd;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    idle_n   = idle_cnt;
    nib      = uart.rd_data[3:0];
    if (pop) begin
      idle_n = '0;
      if (pos == POS_0) begin
        if (is_digit(uart.rd_data)) begin
          shadow_n[27:24] = nib;
          pos_n           = POS_1;
        end
      end else if (byte_ok(pos, uart.rd_data)) begin
        if (is_digit(uart.rd_data)) begin
          shadow_n[{digit_slot(pos), 2'b00} +: 4] = nib;
        end
        if (pos == POS_9) begin
          bcd_n   = {shadow[27:4], nib};
          valid_n = 1'b1;
          pos_n   = POS_0;
        end else begin
          pos_n = pos_e'(pos + 4'd1);
        end
      end else begin
        err_n = 1'b1;
        if (is_digit(uart.rd_data)) begin
          shadow_n[27:24] = nib;
          pos_n           = POS_1;
        end else begin
          pos_n = POS_0;
        end
      end
    end else if (pos != POS_0) begin
      if (idle_cnt == IDLE_LAST) begin
        err_n  = 1'b1;
        pos_n  = POS_0;
        idle_n = '0;
      end else begin
        idle_n = idle_cnt + 1'b1;
      end
    end else begin
      idle_n = '0;
    end
  end

  // Outputs: never back-pressure the RX FIFO, report activity on busy.
  always_comb begin
    uart.rd_uart = pop;
    busy         = pending || (pos != POS_0);
  end

endmodule

// File: tb/tb_uart_time_parser.sv
// Self-checking bench for uart_time_parser: directed frames from the test
// plan plus a randomized byte stream, checked against a character-level model.
module tb_uart_time_parser;

  localparam int T = 20;

  logic        clk;
  logic        rst;
  logic        req;
  logic [27:0] time_bcd;
  logic        time_valid;
  logic        frame_err;
  logic        busy;

  uart_time_parser_if uif ();

  uart_time_parser #(
    .TIMEOUT_CYC(T),
    .REQ_PERIOD (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart       (uif),
    .req        (req),
    .time_bcd   (time_bcd),
    .time_valid (time_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_pulses = 0;
  int err_pulses   = 0;
  int wr_pulses    = 0;

  string tpl  = "DD:RD:RD.D";
  string pool = "0123456789:.xR7";

  // Reference model state: received characters, request flag, outputs.
  logic [7:0]  mbuf [10];
  int          mn;
  int          midle;
  logic [27:0] m_bcd;
  logic        m_valid;
  logic        m_err;
  logic        m_pending;
  logic        m_wr;
  bit          model_live = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit fits(input int idx, input logic [7:0] b);
    byte c;
    c = tpl[idx];
    if (c == "D") return (b >= "0") && (b <= "9");
    if (c == "R") return (b >= "0") && (b <= "5");
    return b == c;
  endfunction

  function automatic logic [27:0] decodeFrame();
    int v;
    byte c;
    v = 0;
    for (int i = 0; i < 10; i++) begin
      c = tpl[i];
      if (c == "D" || c == "R") v = (v << 4) | int'(mbuf[i] - 8'h30);
    end
    return v[27:0];
  endfunction

  task automatic modelConsume(input logic [7:0] b);
    bit dig;
    dig = (b >= "0") && (b <= "9");
    if (mn == 0) begin
      if (dig) begin
        mbuf[0] = b;
        mn = 1;
      end
    end else if (fits(mn, b)) begin
      mbuf[mn] = b;
      mn++;
      if (mn == 10) begin
        m_bcd   = decodeFrame();
        m_valid = 1'b1;
        mn      = 0;
      end
    end else begin
      m_err = 1'b1;
      if (dig) begin
        mbuf[0] = b;
        mn = 1;
      end else begin
        mn = 0;
      end
    end
  endtask

  // Model advances on each rising edge from the inputs stable at that edge.
  always @(posedge clk) begin
    if (rst) begin
      mn = 0; midle = 0; m_bcd = '0; m_valid = 0; m_err = 0;
      m_pending = 0; m_wr = 0;
      model_live = 1;
    end else if (model_live) begin
      m_valid = 0;
      m_err   = 0;
      m_wr      = m_pending && !uif.tx_full;
      m_pending = (m_pending && !m_wr) || req;
      if (!uif.rx_empty) begin
        midle = 0;
        modelConsume(uif.rd_data);
      end else if (mn != 0) begin
        midle++;
        if (midle == T) begin
          m_err = 1;
          mn    = 0;
          midle = 0;
        end
      end else begin
        midle = 0;
      end
    end
  end

  // Every cycle: compare all DUT outputs against the model.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("rd_uart", uif.rd_uart, !uif.rx_empty);
      checkOutput("wr_uart", uif.wr_uart, m_wr);
      checkOutput("wr_data", uif.wr_data, 8'h52);
      checkOutput("time_bcd", time_bcd, m_bcd);
      checkOutput("time_valid", time_valid, m_valid);
      checkOutput("frame_err", frame_err, m_err);
      checkOutput("busy", busy, m_pending || (mn != 0));
      if (time_valid === 1'b1) valid_pulses++;
      if (frame_err === 1'b1) err_pulses++;
      if (uif.wr_uart === 1'b1) wr_pulses++;
    end
  end

  task automatic applyStimulus(input bit empty, input logic [7:0] data, input bit rq, input bit full);
    @(posedge clk);
    #1;
    uif.rx_empty = empty;
    uif.rd_data  = data;
    req          = rq;
    uif.tx_full  = full;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(1'b0, s[i], 1'b0, 1'b0);
  endtask

  task automatic idleTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] q [$];

  task automatic pushFrame(input bit corrupt);
    logic [7:0] f [10];
    byte c;
    for (int i = 0; i < 10; i++) begin
      c = tpl[i];
      if (c == "D") f[i] = 8'(8'h30 + $urandom_range(0, 9));
      else if (c == "R") f[i] = 8'(8'h30 + $urandom_range(0, 5));
      else f[i] = c;
    end
    if (corrupt) f[$urandom_range(1, 9)] = pool[$urandom_range(0, pool.len() - 1)];
    for (int i = 0; i < 10; i++) q.push_back(f[i]);
  endtask

  int v0, e0, w0, lat, gap, sel;
  logic [7:0] d;
  bit e;

  initial begin
    rst = 1'b1; req = 1'b0;
    uif.rx_empty = 1'b1; uif.rd_data = 8'h00; uif.tx_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_bcd", time_bcd, 28'h0);
    checkOutput("reset_busy", busy, 1'b0);

    // Back-to-back good frame.
    v0 = valid_pulses; e0 = err_pulses;
    sendStr("12:34:56.7");
    idleTicks(1);
    @(negedge clk);
    checkOutput("frame1_valid", time_valid, 1'b1);
    checkOutput("frame1_bcd", time_bcd, 28'h1234567);
    checkOutput("model_pin1", m_bcd, 28'h1234567);
    idleTicks(3);
    checkOutput("frame1_valid_cnt", valid_pulses - v0, 1);
    checkOutput("frame1_err_cnt", err_pulses - e0, 0);

    // Leading garbage is dropped silently.
    v0 = valid_pulses; e0 = err_pulses;
    sendStr("xy09:59:59.9");
    idleTicks(1);
    @(negedge clk);
    checkOutput("frame2_bcd", time_bcd, 28'h0959599);
    idleTicks(3);
    checkOutput("frame2_valid_cnt", valid_pulses - v0, 1);
    checkOutput("frame2_err_cnt", err_pulses - e0, 0);

    // Range violation on minutes tens.
    sendStr("12:7");
    idleTicks(1);
    @(negedge clk);
    checkOutput("range_err", frame_err, 1'b1);
    checkOutput("range_bcd_hold", time_bcd, 28'h0959599);
    idleTicks(T + 5);
    sendStr("00:00:01.0");
    idleTicks(1);
    @(negedge clk);
    checkOutput("frame3_valid", time_valid, 1'b1);
    checkOutput("frame3_bcd", time_bcd, 28'h0000010);

    // Timeout of a partial frame.
    idleTicks(2);
    sendStr("12:3");
    lat = -1;
    for (int k = 1; k <= T + 10; k++) begin
      idleTicks(1);
      @(negedge clk);
      if (frame_err === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
    checkOutput("timeout_latency", lat, T);
    idleTicks(1);
    @(negedge clk);
    checkOutput("timeout_busy", busy, 1'b0);
    checkOutput("timeout_bcd_hold", time_bcd, 28'h0000010);

    // Merged requests while TX is full.
    w0 = wr_pulses;
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("req_held_busy", busy, 1'b1);
    checkOutput("req_held_wr_cnt", wr_pulses - w0, 0);
    idleTicks(6);
    checkOutput("req_wr_cnt", wr_pulses - w0, 1);
    checkOutput("req_wr_data", uif.wr_data, 8'h52);

    // Reset in the middle of a frame.
    sendStr("12:34:");
    @(posedge clk);
    #1 rst = 1'b1; uif.rx_empty = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_bcd", time_bcd, 28'h0);
    checkOutput("rst_valid", time_valid, 1'b0);
    checkOutput("rst_err", frame_err, 1'b0);
    checkOutput("rst_wr", uif.wr_uart, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    e0 = err_pulses; v0 = valid_pulses;
    sendStr("23:59:59.9");
    idleTicks(1);
    @(negedge clk);
    checkOutput("frame4_bcd", time_bcd, 28'h2359599);
    idleTicks(T + 5);
    checkOutput("frame4_valid_cnt", valid_pulses - v0, 1);
    checkOutput("frame4_err_cnt", err_pulses - e0, 0);

    // Randomized stream: good, corrupted and stray bytes with gaps.
    gap = 0;
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0 && gap == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 6) pushFrame(1'b0);
        else if (sel < 8) pushFrame(1'b1);
        else if (sel == 8) q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
        else gap = $urandom_range(15, 30);
      end
      e = 1'b1;
      d = 8'($urandom);
      if (gap > 0) begin
        gap--;
      end else if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        e = 1'b0;
        d = q.pop_front();
      end
      applyStimulus(e, d, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end
    idleTicks(T + 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
